// File: rtl/fifo_wr_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb_pkg
// Shared definitions for the FIFO write-port arbiter:
//   - arb_state_e : arbiter FSM encoding (IDLE / GRANT)
//   - DEF_*       : default sizing used by the FIFO top level
//   - clog2_f     : constant-evaluable ceiling log2 for counter/index widths
// -----------------------------------------------------------------------------
package fifo_wr_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_BURST_MAX = 4;
  localparam int DEF_IDLE_TO   = 8;

  // Smallest r with 2**r >= value (value >= 2 in every use here).
  function automatic int clog2_f(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_chk.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb_chk
// Protocol checker for the arbiter's FIFO-facing side. Contains properties
// only; it drives nothing.
// Ports:
//   clk_i       in  1     write-domain clock
//   rst_n_i     in  1     synchronous reset, active low
//   w_en_i      in  1     FIFO write enable from the arbiter
//   w_full_i    in  1     FIFO full flag
//   busy_i      in  1     arbiter grant active
//   req_ready_i in  NREQ  per-requester ready from the arbiter
// -----------------------------------------------------------------------------
module fifo_wr_arb_chk #(
  parameter int NREQ = 4
) (
  input logic            clk_i,
  input logic            rst_n_i,
  input logic            w_en_i,
  input logic            w_full_i,
  input logic            busy_i,
  input logic [NREQ-1:0] req_ready_i
);

  // A full FIFO must never be written.
  a_no_write_when_full : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    w_en_i |-> !w_full_i);

  // Writes only happen on behalf of an active grant.
  a_write_needs_grant : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    w_en_i |-> busy_i);

  // At most one producer is offered the write port at a time.
  a_ready_onehot0 : assert property (@(posedge clk_i)
    $onehot0(req_ready_i));

  // Reset silences the write port and all readies.
  a_quiet_in_reset : assert property (@(posedge clk_i)
    !rst_n_i |-> (!w_en_i && (req_ready_i == {NREQ{1'b0}})));

endmodule

// File: rtl/fifo_wr_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb_rr_pick
// Combinational rotating-priority selector. Searches req_i starting at the
// position after ptr_i (ptr_i+1, ptr_i+2, ... modulo NREQ) and returns the
// first requester found. ptr_i itself is examined last, so the previous
// owner has the lowest priority.
// Ports:
//   req_i   in  NREQ  request vector
//   ptr_i   in  IW    last served index
//   found_o out 1     at least one request is set
//   idx_o   out IW    winning index (0 when found_o is low)
// -----------------------------------------------------------------------------
module fifo_wr_arb_rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = clog2_f(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            found_o,
  output logic [IW-1:0]   idx_o
);

  int cand;

  // Walk the ring once starting after ptr_i; the first hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = {IW{1'b0}};
    cand    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr_i) + k) % NREQ;
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IW'(cand);
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb
// Round-robin arbiter sharing the single write port of the async FIFO among
// NREQ producers in the write clock domain. A grant covers a whole burst
// (until req_last or BURST_MAX beats). Accepted beats pass straight through to
// the FIFO with no added latency; nothing is written while w_full is high.
// A watchdog revokes a grant whose owner keeps req_valid low for IDLE_TO
// non-stalled cycles. Arbitration always takes one IDLE cycle.
// Ports:
//   w_clk_i      in  1             write-domain clock
//   rst_n_i      in  1             synchronous reset, active low
//   req_valid_i  in  NREQ          per-requester beat valid
//   req_data_i   in  NREQ*DW       packed beat data, requester i at [i*DW +: DW]
//   req_last_i   in  NREQ          last beat of the requester's burst
//   req_ready_o  out NREQ          beat accepted when valid & ready
//   w_full_i     in  1             FIFO full flag
//   w_en_o       out 1             FIFO write enable
//   w_data_o     out DW            FIFO write data
//   grant_id_o   out clog2(NREQ)   current owner (holds last owner when idle)
//   busy_o       out 1             a grant is active
// -----------------------------------------------------------------------------
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DW        = DEF_DW,
  parameter int BURST_MAX = DEF_BURST_MAX,
  parameter int IDLE_TO   = DEF_IDLE_TO
) (
  input  logic                       w_clk_i,
  input  logic                       rst_n_i,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [NREQ*DW-1:0]         req_data_i,
  input  logic [NREQ-1:0]            req_last_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic                       w_full_i,
  output logic                       w_en_o,
  output logic [DW-1:0]              w_data_o,
  output logic [clog2_f(NREQ)-1:0]   grant_id_o,
  output logic                       busy_o
);

  localparam int IW  = clog2_f(NREQ);
  localparam int BCW = clog2_f(BURST_MAX + 1);
  localparam int TCW = clog2_f(IDLE_TO + 1);

  localparam logic [BCW-1:0] BURST_LIMIT = BCW'(BURST_MAX);
  localparam logic [TCW-1:0] TO_LIMIT    = TCW'(IDLE_TO);

  arb_state_e     state_q;
  logic [IW-1:0]  rr_ptr_q;
  logic [IW-1:0]  grant_id_q;
  logic           busy_q;
  logic [BCW-1:0] beat_cnt_q;
  logic [BCW-1:0] beat_cnt_d;
  logic [TCW-1:0] to_cnt_q;
  logic [TCW-1:0] to_cnt_d;

  logic           pick_found_s;
  logic [IW-1:0]  pick_idx_s;
  logic           own_valid_s;
  logic           own_last_s;
  logic [DW-1:0]  own_data_s;
  logic           granted_s;
  logic           accept_s;
  logic           idle_tick_s;
  logic           burst_end_s;
  logic           revoke_s;

  fifo_wr_arb_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found_s),
    .idx_o   (pick_idx_s)
  );

  // Select the current owner's request lane.
  always_comb begin
    own_valid_s = req_valid_i[grant_id_q];
    own_last_s  = req_last_i[grant_id_q];
    own_data_s  = req_data_i[int'(grant_id_q)*DW +: DW];
  end

  // Write-port and ready generation; reset gates both immediately so no beat
  // is accepted in the cycle reset is applied.
  always_comb begin
    req_ready_o = {NREQ{1'b0}};
    w_en_o      = 1'b0;
    w_data_o    = own_data_s;
    granted_s   = rst_n_i & (state_q == ST_GRANT);
    if (granted_s) begin
      req_ready_o[grant_id_q] = ~w_full_i;
      w_en_o                  = own_valid_s & ~w_full_i;
    end else begin
      req_ready_o = {NREQ{1'b0}};
      w_en_o      = 1'b0;
    end
  end

  // Burst/watchdog bookkeeping. A full-FIFO stall freezes both counters, so
  // only cycles where the owner itself is silent count toward revocation.
  always_comb begin
    accept_s    = w_en_o;
    beat_cnt_d  = beat_cnt_q + BCW'(1'b1);
    to_cnt_d    = to_cnt_q + TCW'(1'b1);
    idle_tick_s = granted_s & ~own_valid_s & ~w_full_i;
    burst_end_s = accept_s & (own_last_s | (beat_cnt_d == BURST_LIMIT));
    revoke_s    = idle_tick_s & (to_cnt_d == TO_LIMIT);
  end

  // Arbiter FSM with registered grant state.
  always_ff @(posedge w_clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= IW'(NREQ - 1);
      grant_id_q <= {IW{1'b0}};
      busy_q     <= 1'b0;
      beat_cnt_q <= {BCW{1'b0}};
      to_cnt_q   <= {TCW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          beat_cnt_q <= {BCW{1'b0}};
          to_cnt_q   <= {TCW{1'b0}};
          if (pick_found_s) begin
            state_q    <= ST_GRANT;
            grant_id_q <= pick_idx_s;
            busy_q     <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (burst_end_s || revoke_s) begin
            // The owner goes to the back of the ring whether it finished or
            // was revoked.
            state_q    <= ST_IDLE;
            rr_ptr_q   <= grant_id_q;
            busy_q     <= 1'b0;
            beat_cnt_q <= {BCW{1'b0}};
            to_cnt_q   <= {TCW{1'b0}};
          end else if (accept_s) begin
            beat_cnt_q <= beat_cnt_d;
            to_cnt_q   <= {TCW{1'b0}};
          end else if (idle_tick_s) begin
            to_cnt_q <= to_cnt_d;
          end else begin
            to_cnt_q <= to_cnt_q;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          beat_cnt_q <= {BCW{1'b0}};
          to_cnt_q   <= {TCW{1'b0}};
        end
      endcase
    end
  end

  assign grant_id_o = grant_id_q;
  assign busy_o     = busy_q;

  fifo_wr_arb_chk #(
    .NREQ (NREQ)
  ) u_chk (
    .clk_i       (w_clk_i),
    .rst_n_i     (rst_n_i),
    .w_en_i      (w_en_o),
    .w_full_i    (w_full_i),
    .busy_i      (busy_o),
    .req_ready_i (req_ready_o)
  );

endmodule

// File: tb/tb_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arb
// Directed bench for fifo_wr_arb (NREQ=4, DW=8, BURST_MAX=4, IDLE_TO=8).
// Expected FIFO writes (data, owner) are queued before each scenario; a
// monitor pops one entry per observed w_en. Per-cycle control outputs are
// compared against hand-derived values in the stimulus.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arb;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] gid;
  } exp_t;

  localparam logic [1:0] RR_GID [10] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1,
                                         2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

  logic        w_clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        w_full;
  logic        w_en;
  logic [7:0]  w_data;
  logic [1:0]  grant_id;
  logic        busy;

  logic [7:0]  d [4];
  logic        auto_inc;
  int          total = 0;
  int          bad   = 0;
  exp_t        exp_q [$];

  logic        s_wen;
  logic        s_busy;
  logic [3:0]  s_rdy;
  logic [1:0]  s_gid;

  assign req_data = {d[3], d[2], d[1], d[0]};

  fifo_wr_arb #(
    .NREQ      (4),
    .DW        (8),
    .BURST_MAX (4),
    .IDLE_TO   (8)
  ) dut (
    .w_clk_i     (w_clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .w_full_i    (w_full),
    .w_en_o      (w_en),
    .w_data_o    (w_data),
    .grant_id_o  (grant_id),
    .busy_o      (busy)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [7:0] data, input logic [1:0] gid);
    exp_t e;
    e.data = data;
    e.gid  = gid;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // One clock: sample outputs at negedge, then let producers advance their
  // data after every accepted beat (when auto_inc is set).
  task automatic cyc_step();
    logic [3:0] acc;
    @(negedge w_clk);
    s_wen  = w_en;
    s_busy = busy;
    s_rdy  = req_ready;
    s_gid  = grant_id;
    acc    = req_valid & req_ready;
    @(posedge w_clk);
    #1;
    if (auto_inc) begin
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) d[i] = d[i] + 8'd1;
      end
    end
  endtask

  task automatic step_chk(input string nm, input logic ewen, input logic ebusy,
                          input logic [3:0] erdy, input logic [1:0] egid);
    cyc_step();
    chk({nm, ".w_en"},      {7'd0, s_wen},  {7'd0, ewen});
    chk({nm, ".busy"},      {7'd0, s_busy}, {7'd0, ebusy});
    chk({nm, ".req_ready"}, {4'd0, s_rdy},  {4'd0, erdy});
    chk({nm, ".grant_id"},  {6'd0, s_gid},  {6'd0, egid});
  endtask

  // Scoreboard monitor: every write must match the oldest expected beat.
  always @(negedge w_clk) begin
    if (w_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL spurious_write got=data %h gid %0d want=no write", w_data, grant_id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (w_data !== e.data || grant_id !== e.gid) begin
          bad++;
          $display("FAIL fifo_write got=data %h gid %0d want=data %h gid %0d",
                   w_data, grant_id, e.data, e.gid);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_last  = 4'hF;
    w_full    = 1'b0;
    auto_inc  = 1'b0;
    d[0] = 8'h10; d[1] = 8'h11; d[2] = 8'h12; d[3] = 8'h13;

    // Reset held with every requester valid.
    for (int i = 1; i <= 3; i++) begin
      step_chk($sformatf("reset_c%0d", i), 1'b0, 1'b0, 4'b0000, 2'd0);
    end

    // Round-robin fairness with single-beat bursts.
    push(8'h10, 2'd0); push(8'h11, 2'd1); push(8'h12, 2'd2);
    push(8'h13, 2'd3); push(8'h10, 2'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        step_chk($sformatf("rr_s%0d", i + 1), 1'b0, 1'b0, 4'b0000, RR_GID[i]);
      end else begin
        step_chk($sformatf("rr_s%0d", i + 1), 1'b1, 1'b1, 4'b0001 << RR_GID[i], RR_GID[i]);
      end
    end
    req_valid = 4'b0000;
    req_last  = 4'b0000;

    // Burst cap: req1 never asserts last, so the grant ends after 4 beats.
    auto_inc = 1'b1;
    d[1] = 8'h20;
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i), 2'd1);
    req_valid = 4'b0010;
    step_chk("cap_arb", 1'b0, 1'b0, 4'b0000, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      step_chk($sformatf("cap_beat%0d", i), 1'b1, 1'b1, 4'b0010, 2'd1);
    end
    step_chk("cap_gap", 1'b0, 1'b0, 4'b0000, 2'd1);
    step_chk("cap_regrant", 1'b1, 1'b1, 4'b0010, 2'd1);
    req_last = 4'b0010;
    step_chk("cap_last", 1'b1, 1'b1, 4'b0010, 2'd1);
    req_valid = 4'b0000;
    req_last  = 4'b0000;

    // Full stall mid-burst; stalled cycles must not feed the watchdog.
    d[2] = 8'h30;
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i), 2'd2);
    req_valid = 4'b0100;
    step_chk("full_arb", 1'b0, 1'b0, 4'b0000, 2'd1);
    step_chk("full_b1", 1'b1, 1'b1, 4'b0100, 2'd2);
    step_chk("full_b2", 1'b1, 1'b1, 4'b0100, 2'd2);
    w_full = 1'b1;
    step_chk("full_stall_v", 1'b0, 1'b1, 4'b0000, 2'd2);
    req_valid = 4'b0000;
    for (int i = 1; i <= 5; i++) begin
      step_chk($sformatf("full_stall%0d", i), 1'b0, 1'b1, 4'b0000, 2'd2);
    end
    w_full = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step_chk($sformatf("full_quiet%0d", i), 1'b0, 1'b1, 4'b0100, 2'd2);
    end
    req_valid = 4'b0100;
    step_chk("full_b3", 1'b1, 1'b1, 4'b0100, 2'd2);
    step_chk("full_b4", 1'b1, 1'b1, 4'b0100, 2'd2);
    req_valid = 4'b0000;
    step_chk("full_done", 1'b0, 1'b0, 4'b0000, 2'd2);

    // Watchdog: req2 goes silent while req3 waits.
    d[2] = 8'h40;
    d[3] = 8'h50;
    push(8'h40, 2'd2);
    push(8'h50, 2'd3);
    req_valid = 4'b0100;
    step_chk("wd_arb", 1'b0, 1'b0, 4'b0000, 2'd2);
    step_chk("wd_b1", 1'b1, 1'b1, 4'b0100, 2'd2);
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    for (int i = 1; i <= 8; i++) begin
      step_chk($sformatf("wd_silent%0d", i), 1'b0, 1'b1, 4'b0100, 2'd2);
    end
    step_chk("wd_revoked", 1'b0, 1'b0, 4'b0000, 2'd2);
    step_chk("wd_req3", 1'b1, 1'b1, 4'b1000, 2'd3);
    req_valid = 4'b0000;
    req_last  = 4'b0000;

    // Reset mid-burst: two beats written, then arbitration restarts at req0.
    d[0] = 8'h70;
    d[1] = 8'h60;
    push(8'h70, 2'd0); push(8'h60, 2'd1); push(8'h61, 2'd1); push(8'h71, 2'd0);
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    step_chk("mr_arb0", 1'b0, 1'b0, 4'b0000, 2'd3);
    step_chk("mr_w0", 1'b1, 1'b1, 4'b0001, 2'd0);
    req_valid = 4'b0010;
    req_last  = 4'b0000;
    step_chk("mr_arb1", 1'b0, 1'b0, 4'b0000, 2'd0);
    step_chk("mr_b1", 1'b1, 1'b1, 4'b0010, 2'd1);
    step_chk("mr_b2", 1'b1, 1'b1, 4'b0010, 2'd1);
    rst_n = 1'b0;
    step_chk("mr_rst", 1'b0, 1'b1, 4'b0000, 2'd1);
    rst_n     = 1'b1;
    req_valid = 4'b0011;
    req_last  = 4'b0011;
    step_chk("mr_rearb", 1'b0, 1'b0, 4'b0000, 2'd0);
    step_chk("mr_req0", 1'b1, 1'b1, 4'b0001, 2'd0);
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    step_chk("mr_idle", 1'b0, 1'b0, 4'b0000, 2'd0);

    chk("leftover_expected", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
